// File: rtl/param_alu_core.sv
// Parametrised register-file ALU core: switch-bank loads plus a
// four-state read/exec/write sequencer feeding the display path.
module param_alu_core #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             load,
  input  logic [WIDTH-1:0] sw_data,
  input  logic [AW-1:0]    wr_addr,
  input  logic             start,
  input  logic [2:0]       opcode,
  input  logic [AW-1:0]    src_a,
  input  logic [AW-1:0]    src_b,
  input  logic [AW-1:0]    dst,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             z,
  output logic             negative,
  output logic             overflow,
  output logic             busy,
  output logic             done,
  output logic [2:0]       op_last
);

  typedef enum logic [1:0] {IDLE, READ, EXEC, WRITE} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] regs_q [DEPTH];
  logic [2:0]       op_q;
  logic [AW-1:0]    sa_q, sb_q, dst_q;
  logic [WIDTH-1:0] a_q, b_q, alu_q;
  logic             alu_c_q, alu_v_q;
  logic [WIDTH-1:0] res_q;
  logic             c_q, z_q, n_q, v_q, done_q;
  logic [2:0]       op_last_q;

  logic [WIDTH:0]   sum, diff;
  logic [WIDTH-1:0] alu_r;
  logic             alu_c, alu_v;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (!load && start) state_d = READ;
      READ:  state_d = EXEC;
      EXEC:  state_d = WRITE;
      WRITE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    sum   = {1'b0, a_q} + {1'b0, b_q};
    diff  = {1'b0, a_q} - {1'b0, b_q};
    alu_r = '0;
    alu_c = 1'b0;
    alu_v = 1'b0;
    unique case (op_q)
      3'b000: begin
        alu_r = sum[WIDTH-1:0];
        alu_c = sum[WIDTH];
        alu_v = (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                (alu_r[WIDTH-1] != a_q[WIDTH-1]);
      end
      3'b001: begin
        // the extra MSB of the widened difference is the borrow
        alu_r = diff[WIDTH-1:0];
        alu_c = diff[WIDTH];
        alu_v = (a_q[WIDTH-1] != b_q[WIDTH-1]) &&
                (alu_r[WIDTH-1] != a_q[WIDTH-1]);
      end
      3'b010: alu_r = a_q & b_q;
      3'b011: alu_r = a_q | b_q;
      3'b100: alu_r = a_q ^ b_q;
      3'b101: begin
        alu_r = {a_q[WIDTH-2:0], 1'b0};
        alu_c = a_q[WIDTH-1];
      end
      3'b110: begin
        alu_r = {1'b0, a_q[WIDTH-1:1]};
        alu_c = a_q[0];
      end
      3'b111: alu_r = a_q;
      default: alu_r = a_q;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
      op_q      <= '0;
      sa_q      <= '0;
      sb_q      <= '0;
      dst_q     <= '0;
      a_q       <= '0;
      b_q       <= '0;
      alu_q     <= '0;
      alu_c_q   <= 1'b0;
      alu_v_q   <= 1'b0;
      res_q     <= '0;
      c_q       <= 1'b0;
      z_q       <= 1'b0;
      n_q       <= 1'b0;
      v_q       <= 1'b0;
      done_q    <= 1'b0;
      op_last_q <= '0;
    end else begin
      state_q <= state_d;
      done_q  <= (state_q == WRITE);
      unique case (state_q)
        IDLE: begin
          if (load) begin
            regs_q[wr_addr] <= sw_data;
          end else if (start) begin
            op_q  <= opcode;
            sa_q  <= src_a;
            sb_q  <= src_b;
            dst_q <= dst;
          end
        end
        READ: begin
          a_q <= regs_q[sa_q];
          b_q <= regs_q[sb_q];
        end
        EXEC: begin
          alu_q   <= alu_r;
          alu_c_q <= alu_c;
          alu_v_q <= alu_v;
        end
        WRITE: begin
          regs_q[dst_q] <= alu_q;
          res_q         <= alu_q;
          c_q           <= alu_c_q;
          z_q           <= (alu_q == '0);
          n_q           <= alu_q[WIDTH-1];
          v_q           <= alu_v_q;
          op_last_q     <= op_q;
        end
        default: ;
      endcase
    end
  end

  assign result   = res_q;
  assign carry    = c_q;
  assign z        = z_q;
  assign negative = n_q;
  assign overflow = v_q;
  assign busy     = (state_q != IDLE);
  assign done     = done_q;
  assign op_last  = op_last_q;

endmodule

// File: tb/tb_param_alu_core.sv
// Directed bench for param_alu_core: 8-bit/4-reg and 4-bit/8-reg
// instances, hand-computed expectations.
module tb_param_alu_core;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       ld, st;
  logic [7:0] sw;
  logic [1:0] wa, sa, sb, ds;
  logic [2:0] opc;
  logic [7:0] res;
  logic       cy, zf, ng, ov, bsy, dn;
  logic [2:0] opl;

  logic       ld4, st4;
  logic [3:0] sw4;
  logic [2:0] wa4, sa4, sb4, ds4;
  logic [2:0] opc4;
  logic [3:0] res4;
  logic       cy4, zf4, ng4, ov4, bsy4, dn4;
  logic [2:0] opl4;

  int vectors = 0;
  int errs = 0;
  int ndone;

  param_alu_core #(.WIDTH(8), .DEPTH(4)) u8 (
    .clock(clk), .reset_n(rst_n), .load(ld), .sw_data(sw),
    .wr_addr(wa), .start(st), .opcode(opc), .src_a(sa),
    .src_b(sb), .dst(ds), .result(res), .carry(cy), .z(zf),
    .negative(ng), .overflow(ov), .busy(bsy), .done(dn),
    .op_last(opl)
  );

  param_alu_core #(.WIDTH(4), .DEPTH(8)) u4 (
    .clock(clk), .reset_n(rst_n), .load(ld4), .sw_data(sw4),
    .wr_addr(wa4), .start(st4), .opcode(opc4), .src_a(sa4),
    .src_b(sb4), .dst(ds4), .result(res4), .carry(cy4),
    .z(zf4), .negative(ng4), .overflow(ov4), .busy(bsy4),
    .done(dn4), .op_last(opl4)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic load8(input logic [1:0] a, input logic [7:0] d);
    @(negedge clk);
    ld = 1'b1; wa = a; sw = d;
    @(posedge clk); #1;
    ld = 1'b0;
    chk("load_busy", bsy, 0);
  endtask

  task automatic op8(input logic [2:0] op, input logic [1:0] a,
                     input logic [1:0] b, input logic [1:0] d);
    @(negedge clk);
    st = 1'b1; opc = op; sa = a; sb = b; ds = d;
    @(posedge clk); #1;
    st = 1'b0;
    chk("busy_e0", bsy, 1);
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      chk("done_early", dn, 0);
    end
    @(posedge clk); #1;
    chk("done_lat", dn, 1);
    chk("busy_end", bsy, 0);
  endtask

  task automatic load4(input logic [2:0] a, input logic [3:0] d);
    @(negedge clk);
    ld4 = 1'b1; wa4 = a; sw4 = d;
    @(posedge clk); #1;
    ld4 = 1'b0;
  endtask

  initial begin
    ld = 0; st = 0; sw = 0; wa = 0; sa = 0; sb = 0; ds = 0; opc = 0;
    ld4 = 0; st4 = 0; sw4 = 0; wa4 = 0; sa4 = 0; sb4 = 0; ds4 = 0;
    opc4 = 0;
    #12;
    chk("rst_result", res, 0);
    chk("rst_flags", {cy, zf, ng, ov}, 0);
    chk("rst_busy", bsy, 0);
    chk("rst_done", dn, 0);
    chk("rst_oplast", opl, 0);
    @(negedge clk);
    rst_n = 1'b1;

    load8(2'd0, 8'hF0);
    load8(2'd1, 8'h20);
    op8(3'b000, 2'd0, 2'd1, 2'd2);
    chk("add_res", res, 8'h10);
    chk("add_cvzn", {cy, ov, zf, ng}, 4'b1000);
    chk("add_oplast", opl, 3'b000);
    op8(3'b111, 2'd2, 2'd0, 2'd3);
    chk("mov_r2", res, 8'h10);

    op8(3'b001, 2'd0, 2'd0, 2'd0);
    chk("sub_self_res", res, 8'h00);
    chk("sub_self_fl", {cy, ov, zf, ng}, 4'b0010);
    load8(2'd0, 8'hF0);
    op8(3'b001, 2'd1, 2'd0, 2'd3);
    chk("sub_brw_res", res, 8'h30);
    chk("sub_brw_fl", {cy, ov, zf, ng}, 4'b1000);

    load8(2'd0, 8'h7F);
    load8(2'd1, 8'h01);
    op8(3'b000, 2'd0, 2'd1, 2'd2);
    chk("add_ovf_res", res, 8'h80);
    chk("add_ovf_fl", {cy, ov, zf, ng}, 4'b0101);

    load8(2'd0, 8'h81);
    op8(3'b101, 2'd0, 2'd0, 2'd2);
    chk("shl_res", res, 8'h02);
    chk("shl_c", cy, 1);
    op8(3'b110, 2'd0, 2'd0, 2'd2);
    chk("shr_res", res, 8'h40);
    chk("shr_c", cy, 1);
    chk("shr_oplast", opl, 3'b110);

    load8(2'd2, 8'h99);
    chk("load_hold_res", res, 8'h40);
    chk("load_hold_c", cy, 1);

    // start and load arriving while busy must be dropped
    @(negedge clk);
    st = 1'b1; opc = 3'b000; sa = 2'd0; sb = 2'd1; ds = 2'd2;
    @(posedge clk); #1;
    st = 1'b0;
    @(negedge clk);
    st = 1'b1; opc = 3'b100; ld = 1'b1; wa = 2'd3; sw = 8'hAA;
    @(posedge clk); #1;
    st = 1'b0; ld = 1'b0;
    ndone = 0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      if (dn) ndone++;
    end
    chk("busy_one_done", ndone, 1);
    chk("busy_res", res, 8'h82);
    chk("busy_oplast", opl, 3'b000);
    op8(3'b111, 2'd3, 2'd0, 2'd3);
    chk("busy_no_load", res, 8'h30);

    @(negedge clk);
    ld = 1'b1; st = 1'b1; wa = 2'd1; sw = 8'h11;
    opc = 3'b101; sa = 2'd1; ds = 2'd1;
    @(posedge clk); #1;
    ld = 1'b0; st = 1'b0;
    chk("ldst_busy", bsy, 0);
    ndone = 0;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      if (dn || bsy) ndone++;
    end
    chk("ldst_no_op", ndone, 0);
    op8(3'b111, 2'd1, 2'd0, 2'd1);
    chk("ldst_loaded", res, 8'h11);

    load8(2'd3, 8'h55);
    @(negedge clk);
    st = 1'b1; opc = 3'b000; sa = 2'd0; sb = 2'd1; ds = 2'd3;
    @(posedge clk); #1;
    st = 1'b0;
    @(posedge clk); #1;
    chk("pre_rst_busy", bsy, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", bsy, 0);
    chk("mid_rst_res", res, 0);
    chk("mid_rst_oplast", opl, 0);
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      if (dn) ndone++;
    end
    chk("mid_rst_nodone", ndone, 0);
    for (int r = 0; r < 4; r++) begin
      op8(3'b111, 2'(r), 2'(r), 2'(r));
      chk("rst_reg_zero", res, 0);
      chk("rst_reg_z", zf, 1);
    end

    load4(3'd7, 4'hF);
    load4(3'd6, 4'h1);
    @(negedge clk);
    st4 = 1'b1; opc4 = 3'b000; sa4 = 3'd7; sb4 = 3'd6; ds4 = 3'd5;
    @(posedge clk); #1;
    st4 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("w4_done_early", dn4, 0);
    @(posedge clk); #1;
    chk("w4_done", dn4, 1);
    chk("w4_res", res4, 4'h0);
    chk("w4_fl", {cy4, zf4, ov4, ng4}, 4'b1100);
    @(negedge clk);
    st4 = 1'b1; opc4 = 3'b111; sa4 = 3'd5; ds4 = 3'd4;
    @(posedge clk); #1;
    st4 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("w4_mov_r5", res4, 4'h0);
    chk("w4_oplast", opl4, 3'b111);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule

// File: doc/param_alu_core.md
Name: param_alu_core

Overview:
- Parametrised successor to the team's fixed 4-bit two-register ALU datapath.
- Contains a DEPTH-entry register file of WIDTH-bit registers, loaded from the switch bank.
- A multi-cycle FSM executes 3-bit opcodes: read two source registers, compute, write back to a destination register.
- Drives result, flags and the last opcode out to the existing 7-segment display path.

Parameters:
- WIDTH, 8, datapath and register width in bits (>=2).
- DEPTH, 4, number of registers (power of two, >=2).
- AW, $clog2(DEPTH), register address width (derived; not overridden).

Ports:
- clock  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- load  in  1  write sw_data into register wr_addr (accepted only in IDLE).
- sw_data  in  WIDTH  switch value to load.
- wr_addr  in  AW  register written by load.
- start  in  1  begin an operation (accepted only in IDLE).
- opcode  in  3  operation select.
- src_a  in  AW  first operand register.
- src_b  in  AW  second operand register.
- dst  in  AW  writeback register.
- result  out  WIDTH  last completed result (registered).
- carry  out  1  carry/borrow/shift-out flag.
- z  out  1  result==0.
- negative  out  1  result MSB.
- overflow  out  1  signed overflow (ADD/SUB only).
- busy  out  1  high in any state except IDLE.
- done  out  1  one-cycle pulse on completion.
- op_last  out  3  opcode of last completed operation (display feed).

Behaviour:
- Reset (async, reset_n=0):
  - All registers = 0.
  - result, flags, done, op_last = 0.
  - State = IDLE, busy = 0.
- FSM states: IDLE -> READ -> EXEC -> WRITE -> IDLE.
- Edge E0, in IDLE:
  - If load=1, write regs[wr_addr] <= sw_data and stay in IDLE.
  - Else if start=1, latch opcode, src_a, src_b, dst; go to READ.
  - load has priority: simultaneous load+start does the load, and start is dropped (not queued).
- E1 (READ->EXEC): operands A=regs[src_a], B=regs[src_b] latched.
- E2 (EXEC->WRITE): ALU output and flags latched internally.
- E3 (WRITE->IDLE):
  - regs[dst], result, carry, z, negative, overflow and op_last updated.
  - done=1 for exactly the cycle after E3.
- Latency: result valid and done high 3 cycles after the start edge.
- busy is high from after E0 until E3.
- Back-to-back: start may be asserted in the done cycle and is accepted (state is IDLE).
- start or load while busy: ignored, with no side effects.
- src_a==src_b==dst is legal: operands are read before writeback.
- Opcodes (all results truncated to WIDTH):
  - 000 ADD: A+B; carry=bit WIDTH of the sum.
  - 001 SUB: A-B; carry=1 iff A<B unsigned (borrow).
  - 010 AND, 011 OR, 100 XOR: carry=0.
  - 101 SHL: A<<1; carry=A[WIDTH-1].
  - 110 SHR (logical): A>>1; carry=A[0].
  - 111 MOV: A; carry=0.
- Flags on every opcode:
  - z = (result==0).
  - negative = result[WIDTH-1].
  - overflow: ADD → operands same sign and result sign differs; SUB → operands differ in sign and result sign differs from A; all other opcodes → 0.
- Flags and result hold until the next completed operation; a load does not change them.
- Reset mid-operation: aborts immediately, no writeback, all state cleared.
- Wrap-around: ADD/SUB wrap modulo 2^WIDTH; no saturation.

Test Plan:
- WIDTH=8: load r0=0xF0, r1=0x20; ADD src 0,1 dst 2 -> done exactly 3 cycles after start; result=0x10, carry=1, z=0, overflow=0, negative=0; r2=0x10 (check via MOV r2->r3: result=0x10).
- SUB r0-r0 dst r0 (r0=0xF0) -> result=0x00, z=1, carry=0, overflow=0; then SUB 0x20-0xF0 -> result=0x30, carry=1.
- ADD 0x7F+0x01 -> result=0x80, overflow=1, negative=1, carry=0; SHL 0x81 -> 0x02, carry=1; SHR 0x81 -> 0x40, carry=1; op_last=110.
- Handshake: pulse start during READ with a different opcode -> ignored, and only one done pulse occurs. Simultaneous load+start in IDLE -> register written, busy stays 0.
- Assert reset_n=0 during EXEC of ADD dst r3 (r3=0x55 beforehand) -> busy=0, done never pulses, all registers read 0 after reset.
- WIDTH=4, DEPTH=8 instance: load r7=0xF, r6=0x1; ADD dst r5 -> result=0x0, carry=1, z=1.
